// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver: parity encodings,
// FSM state codes and the legal data-width range.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } par_t;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] PARITY    = 3'd3;
   localparam logic [2:0] STOP1     = 3'd4;
   localparam logic [2:0] STOP2     = 3'd5;
   localparam logic [2:0] WAIT_HIGH = 3'd6;

   localparam int DATA_W_MIN = 5;
   localparam int DATA_W_MAX = 9;

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receive-side holding-register handshake: the receiver (master) presents a
// word with status flags, the consumer (slave) accepts it with data_ready.
interface uart_rx_cfg_if #(parameter int DATA_W = 8);

   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              data_ready;
   logic              par_err;
   logic              fr_err;
   logic              brk_det;
   logic              ovr_err;

   modport master (
      output data_out, data_valid, par_err, fr_err, brk_det, ovr_err,
      input  data_ready
   );

   modport slave (
      input  data_out, data_valid, par_err, fr_err, brk_det, ovr_err,
      output data_ready
   );

endinterface

// File: rtl/uart_rx_cfg_sampler.sv
// Line synchronizer and bit-decision filter. With UART_RX_MAJORITY_EN each
// decision is the 2-of-3 vote of the last three s_tick samples.
module uart_rx_sampler (
   input  logic clk,
   input  logic reset_n,
   input  logic i_rx,
   input  logic i_s_tick,
   output logic o_rxs,
   output logic o_bit_val
);

   logic [1:0] r_sync;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the two sync stages into one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_sync <= 2'b11;
      else          r_sync <= {r_sync[0], i_rx};
   end

   assign o_rxs = r_sync[1];

`ifdef UART_RX_MAJORITY_EN
   // r_hist[0]/[1] hold the samples from one and two ticks before the current one.
   logic [1:0] r_hist;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      r_hist <= 2'b11;
      else if (i_s_tick) r_hist <= {r_hist[0], r_sync[1]};
   end

   assign o_bit_val = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_sync[1]) |
                      (r_hist[0] & r_sync[1]);
`else
   logic w_unused_tick;
   assign w_unused_tick = i_s_tick;
   assign o_bit_val     = r_sync[1];
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (5..9 data bits, none/even/odd parity,
// 1 or 2 stop bits) with a valid/ready holding register. Optional macro:
// UART_RX_MAJORITY_EN selects 3-sample majority bit decisions.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OVS    = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          rx,
   input  logic          s_tick,
   input  logic [1:0]    cfg_parity,
   input  logic          cfg_two_stop,
   uart_rx_cfg_if.master rx_if
);

   localparam int S_W = $clog2(OVS);
   localparam int N_W = $clog2(DATA_W);
   localparam logic [S_W-1:0] S_MID  = S_W'(OVS / 2 - 1);
   localparam logic [S_W-1:0] S_END  = S_W'(OVS - 1);
   localparam logic [N_W-1:0] N_LAST = N_W'(DATA_W - 1);

   logic              w_rxs;
   logic              w_bit;
   logic              w_done;
   logic              w_ferr;
   logic              w_brk;

   logic [2:0]        r_state;
   logic [S_W-1:0]    r_s;
   logic [N_W-1:0]    r_n;
   logic [DATA_W-1:0] r_shift;
   logic              r_acc;
   logic              r_pbit;
   logic              r_perr;
   logic              r_stop_err;
   par_t              r_par_sh;
   logic              r_two_sh;

   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              r_par_err;
   logic              r_fr_err;
   logic              r_brk;
   logic              r_ovr;

   uart_rx_sampler u_sampler (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_rx      (rx),
      .i_s_tick  (s_tick),
      .o_rxs     (w_rxs),
      .o_bit_val (w_bit)
   );

   // Completion is the tick that samples the final stop bit.
   assign w_done = s_tick && (r_s == S_END) &&
                   (((r_state == STOP1) && !r_two_sh) || (r_state == STOP2));
   assign w_ferr = r_stop_err | ~w_bit;
   assign w_brk  = w_ferr && (r_shift == '0) && ((r_par_sh == PAR_NONE) || !r_pbit);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_s        <= '0;
         r_n        <= '0;
         r_shift    <= '0;
         r_acc      <= 1'b0;
         r_pbit     <= 1'b0;
         r_perr     <= 1'b0;
         r_stop_err <= 1'b0;
         r_par_sh   <= PAR_NONE;
         r_two_sh   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_rxs) begin
                  r_par_sh <= (cfg_parity == 2'b11) ? PAR_NONE : par_t'(cfg_parity);
                  r_two_sh <= cfg_two_stop;
                  r_s      <= '0;
                  r_state  <= START;
               end
            end
            WAIT_HIGH: begin
               if (w_rxs) r_state <= IDLE;
            end
            START: begin
               if (s_tick) begin
                  if (r_s != S_MID) begin
                     r_s <= r_s + 1'b1;
                  end else if (!w_bit) begin
                     r_s        <= '0;
                     r_n        <= '0;
                     r_acc      <= 1'b0;
                     r_pbit     <= 1'b0;
                     r_perr     <= 1'b0;
                     r_stop_err <= 1'b0;
                     r_state    <= DATA;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            DATA, PARITY, STOP1, STOP2: begin
               if (s_tick) begin
                  if (r_s != S_END) begin
                     r_s <= r_s + 1'b1;
                  end else begin
                     r_s <= '0;
                     case (r_state)
                        DATA: begin
                           r_shift <= {w_bit, r_shift[DATA_W-1:1]};
                           r_acc   <= r_acc ^ w_bit;
                           if (r_n == N_LAST)
                              r_state <= (r_par_sh == PAR_NONE) ? STOP1 : PARITY;
                           else
                              r_n <= r_n + 1'b1;
                        end
                        PARITY: begin
                           r_pbit  <= w_bit;
                           r_perr  <= (r_par_sh == PAR_EVEN) ? (r_acc ^ w_bit) : ~(r_acc ^ w_bit);
                           r_state <= STOP1;
                        end
                        STOP1: begin
                           r_stop_err <= ~w_bit;
                           if (r_two_sh) r_state <= STOP2;
                           else          r_state <= w_bit ? IDLE : WAIT_HIGH;
                        end
                        default: begin
                           r_state <= w_bit ? IDLE : WAIT_HIGH;
                        end
                     endcase
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // A full register with no same-cycle accept drops the new frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_par_err <= 1'b0;
         r_fr_err  <= 1'b0;
         r_brk     <= 1'b0;
         r_ovr     <= 1'b0;
      end else begin
         r_ovr <= 1'b0;
         if (w_done) begin
            if (!r_valid || rx_if.data_ready) begin
               r_data    <= r_shift;
               r_par_err <= r_perr;
               r_fr_err  <= w_ferr;
               r_brk     <= w_brk;
               r_valid   <= 1'b1;
            end else begin
               r_ovr <= 1'b1;
            end
         end else if (r_valid && rx_if.data_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx_if.data_out   = r_data;
   assign rx_if.data_valid = r_valid;
   assign rx_if.par_err    = r_par_err;
   assign rx_if.fr_err     = r_fr_err;
   assign rx_if.brk_det    = r_brk;
   assign rx_if.ovr_err    = r_ovr;

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised, runtime-configurable UART receiver, the successor to the fixed 8N1+parity receiver. It supports 5..9 data bits, none/even/odd parity and 1 or 2 stop bits. Output uses a valid/ready holding register with overrun, parity, framing and break reporting. It sits between the shared baud-tick generator (s_tick at OVS x baud) and the RX FIFO/host interface.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
OVS, 16, s_tick pulses per bit; legal values are even numbers >= 8.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rx  in  1  serial line, idle high, asynchronous to clk
s_tick  in  1  one-cycle oversampling enable
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none
cfg_two_stop  in  1  1 = two stop bits
data_out  out  DATA_W  received word, LSB = first bit on the line
data_valid  out  1  holding register full
data_ready  in  1  consumer accepts the word on a clk edge where data_valid=1
par_err  out  1  parity error of the held word; valid while data_valid=1
fr_err  out  1  framing error of the held word; valid while data_valid=1
brk_det  out  1  break flag of the held word; valid while data_valid=1
ovr_err  out  1  one-cycle pulse when a completed frame is dropped

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, counters 0. Synchronizer flops reset to 1.
- Reset mid-frame aborts the frame and discards the held word.
- rx passes through a 2-flop synchronizer; the FSM sees only rxs.
- Counters: s counts s_tick within a bit (0..OVS-1); n counts data bits (0..DATA_W-1). All FSM actions occur only in cycles with s_tick=1, except IDLE and WAIT_HIGH, which are evaluated every cycle.
- IDLE: on rxs=0, capture cfg_parity and cfg_two_stop into shadow registers, s<=0, go to START. Config changes mid-frame are ignored.
- START: at s==OVS/2-1, sample the line:
  - sample 0: s<=0, n<=0, parity accumulator<=0, go to DATA.
  - sample 1: glitch; go to IDLE with no output.
- DATA: at s==OVS-1, sample the bit and shift it in from the MSB side (LSB first); accumulator^=bit; s<=0.
  - After bit n==DATA_W-1, go to PARITY if the shadow parity is even/odd, else go to STOP1.
- PARITY: at s==OVS-1, perr = (acc^bit) for even, ~(acc^bit) for odd; go to STOP1.
- STOP1: at s==OVS-1, record stop bit. If shadow two_stop=1, go to STOP2, else complete.
- STOP2: at s==OVS-1, record stop bit and complete.
- Completion:
  - ferr = any stop sample was 0.
  - brk = ferr AND all data bits 0 AND (parity disabled OR parity bit 0).
  - Next state: IDLE if the last stop sample was 1, else WAIT_HIGH.
- WAIT_HIGH: stay until rxs=1, then go to IDLE. This prevents a break from re-triggering start.
- Holding register:
  - On completion, if data_valid=0, or data_valid=1 and data_ready=1 in the same cycle: load data_out/par_err/fr_err/brk_det; data_valid<=1.
  - If data_valid=1 and data_ready=0: drop the new frame, keep the old word, ovr_err=1 for one cycle.
  - data_ready=1 with data_valid=1 and no completion: data_valid<=0.
  - data_ready while data_valid=0: no effect.
- Latency: data_valid rises on the clk edge after the s_tick in which the last stop bit is sampled.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: each bit decision (start, data, parity, stop) is the 2-of-3 majority of rxs sampled on the three s_ticks ending at the nominal sample point (s==P-2, P-1, P; P = OVS/2-1 for START, OVS-1 otherwise). The START glitch check uses the majority.
- Undefined: single sample at P; no extra flops.

Decomposition:
- Package uart_pkg: parity encodings PAR_NONE/PAR_EVEN/PAR_ODD; FSM state enum IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH; DATA_W range constants.
- Sub-module uart_rx_sampler: synchronizer plus optional majority filter. Inputs rx, s_tick, sample-point strobe; outputs rxs and bit_val.

Test Plan:
- DATA_W=8, parity none, 1 stop, send 0xA5 -> data_out=0xA5, data_valid=1, all error flags 0; data_ready pulse -> data_valid=0 next cycle.
- DATA_W=9, even parity, 2 stop, send 0x1FF with parity bit 0 -> data_out=0x1FF, par_err=1; resend with parity 1 -> par_err=0.
- Odd parity, send 0x00 with parity 1, second stop bit 0 -> fr_err=1, brk_det=0.
- rx held low for 2 frame times -> fr_err=1, brk_det=1; FSM in WAIT_HIGH; no second word until rx returns high.
- Two frames 0x11, 0x22 with data_ready=0 -> data_out=0x11, ovr_err pulses once; repeat with data_ready asserted in the completion cycle -> data_out=0x22, no ovr_err.
- rx low pulse of OVS/4 ticks -> no frame; with UART_RX_MAJORITY_EN, a single-tick mid-bit inversion in 0x3C -> data_out=0x3C. Reset asserted mid-DATA -> all outputs 0, next frame received correctly.
